// File: rtl/alu_exec_stage.sv
// Execute-stage wrapper around an external combinational ALU: operand stage X feeds the ALU,
// result stage W offers the outcome to writeback, with divide-by-zero/illegal handling and a retire counter.
module alu_exec_stage #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned RD_BITS  = 5,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [WIDTH-1:0]    in_value1,
  input  logic [WIDTH-1:0]    in_value2,
  input  logic [RD_BITS-1:0]  in_rd,
  output logic [3:0]          alu_opcode,
  output logic [WIDTH-1:0]    alu_value1,
  output logic [WIDTH-1:0]    alu_value2,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [RD_BITS-1:0]  out_rd,
  output logic                out_dz,
  output logic                out_illegal,
  output logic [CNT_BITS-1:0] retired_count
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_XOR  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_REM  = 4'd8,
    OP_NOT  = 4'd9
  } op_e;

  logic                x_valid_q,   x_valid_d;
  logic [3:0]          x_opcode_q,  x_opcode_d;
  logic [WIDTH-1:0]    x_value1_q,  x_value1_d;
  logic [WIDTH-1:0]    x_value2_q,  x_value2_d;
  logic [RD_BITS-1:0]  x_rd_q,      x_rd_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_result_q, out_result_d;
  logic [RD_BITS-1:0]  out_rd_q,    out_rd_d;
  logic                out_dz_q,    out_dz_d;
  logic                out_ill_q,   out_ill_d;
  logic [CNT_BITS-1:0] count_q,     count_d;

  logic w_adv;
  logic accept;
  logic w_consume;
  logic x_is_div;
  logic x_is_rem;
  logic x_zero_div;
  logic x_illegal;

  always_comb begin
    w_adv      = x_valid_q & (~out_valid_q | out_ready);
    in_ready   = ~flush & (~x_valid_q | w_adv);
    accept     = in_valid & in_ready;
    w_consume  = out_valid_q & out_ready;
    x_is_div   = (x_opcode_q == OP_DIV);
    x_is_rem   = (x_opcode_q == OP_REM);
    x_zero_div = (x_is_div | x_is_rem) & (x_value2_q == '0);
    x_illegal  = (x_opcode_q == OP_NONE) | (x_opcode_q > OP_NOT);
  end

  always_comb begin
    x_valid_d    = x_valid_q;
    x_opcode_d   = x_opcode_q;
    x_value1_d   = x_value1_q;
    x_value2_d   = x_value2_q;
    x_rd_d       = x_rd_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_dz_d     = out_dz_q;
    out_ill_d    = out_ill_q;
    count_d      = count_q;

    if (accept) begin
      x_valid_d  = 1'b1;
      x_opcode_d = in_opcode;
      x_value1_d = in_value1;
      x_value2_d = in_value2;
      x_rd_d     = in_rd;
    end else if (w_adv) begin
      x_valid_d = 1'b0;
    end

    // Zero-divisor and illegal results bypass alu_result entirely.
    if (w_adv) begin
      out_valid_d = 1'b1;
      out_rd_d    = x_rd_q;
      out_dz_d    = x_zero_div;
      out_ill_d   = x_illegal;
      if (x_zero_div && x_is_div) begin
        out_result_d = '1;
      end else if (x_zero_div || x_illegal) begin
        out_result_d = x_value1_q;
      end else begin
        out_result_d = alu_result;
      end
    end else if (w_consume) begin
      out_valid_d = 1'b0;
    end

    if (w_consume) begin
      count_d = count_q + 1'b1;
    end

    if (flush) begin
      x_valid_d   = 1'b0;
      out_valid_d = 1'b0;
      count_d     = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_valid_q    <= 1'b0;
      x_opcode_q   <= '0;
      x_value1_q   <= '0;
      x_value2_q   <= '0;
      x_rd_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_dz_q     <= 1'b0;
      out_ill_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      x_valid_q    <= x_valid_d;
      x_opcode_q   <= x_opcode_d;
      x_value1_q   <= x_value1_d;
      x_value2_q   <= x_value2_d;
      x_rd_q       <= x_rd_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_dz_q     <= out_dz_d;
      out_ill_q    <= out_ill_d;
      count_q      <= count_d;
    end
  end

  assign alu_opcode    = x_opcode_q;
  assign alu_value1    = x_value1_q;
  assign alu_value2    = x_value2_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd        = out_rd_q;
  assign out_dz        = out_dz_q;
  assign out_illegal   = out_ill_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a behavioural ALU model, a vector table, a result scoreboard
// and hand-written sequences for reset, backpressure, flush and counter wrap.
module tb_alu_exec_stage;

  localparam int unsigned W  = 64;
  localparam int unsigned RB = 5;
  localparam int unsigned CB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [W-1:0]  in_value1;
  logic [W-1:0]  in_value2;
  logic [RB-1:0] in_rd;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_value1;
  logic [W-1:0]  alu_value2;
  logic [W-1:0]  alu_result;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [RB-1:0] out_rd;
  logic          out_dz;
  logic          out_illegal;
  logic [CB-1:0] retired_count;

  alu_exec_stage #(.WIDTH(W), .RD_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_value1(in_value1), .in_value2(in_value2), .in_rd(in_rd),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_dz(out_dz), .out_illegal(out_illegal),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // External ALU; a zero divisor yields junk so the stage override is observable.
  always_comb begin
    case (alu_opcode)
      4'd1:    alu_result = alu_value1 + alu_value2;
      4'd2:    alu_result = alu_value1 - alu_value2;
      4'd3:    alu_result = alu_value1 * alu_value2;
      4'd4:    alu_result = (alu_value2 == '0) ? 64'h5A5A_5A5A_5A5A_5A5A : alu_value1 / alu_value2;
      4'd5:    alu_result = alu_value1 ^ alu_value2;
      4'd6:    alu_result = alu_value1 & alu_value2;
      4'd7:    alu_result = alu_value1 | alu_value2;
      4'd8:    alu_result = (alu_value2 == '0) ? 64'hA5A5_A5A5_A5A5_A5A5 : alu_value1 % alu_value2;
      4'd9:    alu_result = ~alu_value1;
      default: alu_result = alu_value1;
    endcase
  end

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  v1;
    logic [W-1:0]  v2;
    logic [RB-1:0] rd;
    logic [W-1:0]  res;
    logic          dz;
    logic          ill;
  } vec_t;

  localparam int unsigned NV = 16;
  vec_t tbl [NV];
  vec_t sb[$];

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [CB-1:0] exp_cnt = '0;
  logic rand_rdy = 1'b0;

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] v1, input logic [W-1:0] v2,
                              input logic [RB-1:0] rd, input logic [W-1:0] res,
                              input logic dz, input logic ill);
    vec_t v;
    v.op = op; v.v1 = v1; v.v2 = v2; v.rd = rd; v.res = res; v.dz = dz; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int unsigned n = 0;
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_value1 = v.v1;
    in_value2 = v.v2;
    in_rd     = v.rd;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("send_timeout");
    else sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: the negedge sees the inputs that the following posedge will act on.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_cnt = '0;
        sb.delete();
      end else begin
        check("retired_count", 64'(retired_count), 64'(exp_cnt));
        if (out_valid && out_ready && !flush) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = sb.pop_front();
            check("out_result", out_result, e.res);
            check("out_rd", 64'(out_rd), 64'(e.rd));
            check("out_flags", 64'({out_dz, out_illegal}), 64'({e.dz, e.ill}));
          end
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(4'd1, 64'd5, 64'd7, 5'd3, 64'd12, 1'b0, 1'b0);
    tbl[1]  = mk(4'd4, 64'd100, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    tbl[2]  = mk(4'd8, 64'd100, 64'd0, 5'd5, 64'd100, 1'b1, 1'b0);
    tbl[3]  = mk(4'd12, 64'hAB, 64'd1, 5'd6, 64'hAB, 1'b0, 1'b1);
    tbl[4]  = mk(4'd2, 64'd9, 64'd4, 5'd7, 64'd5, 1'b0, 1'b0);
    tbl[5]  = mk(4'd3, 64'd3, 64'd4, 5'd8, 64'd12, 1'b0, 1'b0);
    tbl[6]  = mk(4'd5, 64'hF0, 64'h0F, 5'd9, 64'hFF, 1'b0, 1'b0);
    tbl[7]  = mk(4'd6, 64'hF0F0, 64'h3C3C, 5'd10, 64'h3030, 1'b0, 1'b0);
    tbl[8]  = mk(4'd7, 64'hF000, 64'h000F, 5'd11, 64'hF00F, 1'b0, 1'b0);
    tbl[9]  = mk(4'd9, 64'h0F, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
    tbl[10] = mk(4'd4, 64'd100, 64'd7, 5'd13, 64'd14, 1'b0, 1'b0);
    tbl[11] = mk(4'd8, 64'd100, 64'd7, 5'd14, 64'd2, 1'b0, 1'b0);
    tbl[12] = mk(4'd0, 64'h1234, 64'd5, 5'd15, 64'h1234, 1'b0, 1'b1);
    tbl[13] = mk(4'd15, 64'h55, 64'd0, 5'd31, 64'h55, 1'b0, 1'b1);
    tbl[14] = mk(4'd2, 64'd0, 64'd1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    tbl[15] = mk(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'd1, 1'b0, 1'b0);

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_value1 = '0; in_value2 = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_alu_value1", alu_value1, 64'd0);
    check("reset_out_result", out_result, 64'd0);
    reset_n = 1'b1;

    // Asynchronous reset while two ops are in flight.
    send(mk(4'd1, 64'd1, 64'd1, 5'd1, 64'd2, 1'b0, 1'b0));
    send(mk(4'd1, 64'd2, 64'd2, 5'd2, 64'd4, 1'b0, 1'b0));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_count", 64'(retired_count), 64'd0);
    check("async_alu_value1", alu_value1, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single ADD latency.
    out_ready = 1'b1;
    send(tbl[0]);
    check("add_lat_edge1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("add_lat_edge2", 64'(out_valid), 64'd1);
    check("add_result", out_result, 64'd12);
    check("add_rd", 64'(out_rd), 64'd3);
    @(posedge clk);
    #1;
    check("add_count", 64'(retired_count), 64'd1);
    check("add_drained", 64'(out_valid), 64'd0);

    // Table, back to back at full throughput.
    for (int i = 0; i < NV; i++) send(tbl[i]);
    drain();

    // Table again under random writeback backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < NV; i++) send(tbl[i]);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Backpressure: X fills once, then in_ready drops; order preserved after release.
    do_reset();
    out_ready = 1'b0;
    send(tbl[4]);
    send(tbl[5]);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_w_holds", out_result, 64'd5);
    fork
      send(tbl[6]);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_held", 64'(in_ready), 64'd0);
        check("bp_w_still", out_result, 64'd5);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(retired_count), 64'd3);

    // Flush with two ops in flight and a third offered in the flush cycle.
    out_ready = 1'b0;
    send(tbl[7]);
    send(tbl[8]);
    in_valid = 1'b1; in_opcode = 4'd1; in_value1 = 64'd77; in_value2 = 64'd1; in_rd = 5'd20;
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("flush_no_ghost", 64'(out_valid), 64'd0);
    end
    check("flush_count", 64'(retired_count), 64'd3);

    // Counter wrap with a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++)
      send(mk(4'd1, 64'(i), 64'(i), 5'(i), 64'(2 * i), 1'b0, 1'b0));
    drain();
    check("wrap_count_15", 64'(retired_count), 64'd15);
    send(tbl[6]);
    drain();
    check("wrap_count_0", 64'(retired_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
